// File: rtl/temporizador_leds_jogada_if.sv
// Handshake bundle between the game control unit / board I/O and the timing
// and button responder.
interface temporizador_leds_jogada_if;
  logic       estado_ledsOn;
  logic       estado_ledsOff;
  logic       estado_espera;
  logic [3:0] dado_memoria;
  logic [3:0] botoes;
  logic       fimLedsOn;
  logic       fimLedsOff;
  logic       timeout;
  logic       tem_jogada;
  logic [3:0] jogada;
  logic [3:0] leds;

  modport master (
    output estado_ledsOn, estado_ledsOff, estado_espera, dado_memoria, botoes,
    input  fimLedsOn, fimLedsOff, timeout, tem_jogada, jogada, leds
  );

  modport slave (
    input  estado_ledsOn, estado_ledsOff, estado_espera, dado_memoria, botoes,
    output fimLedsOn, fimLedsOff, timeout, tem_jogada, jogada, leds
  );
endinterface

// File: rtl/temporizador_leds_jogada.sv
// Phase timers (LED on/off, player timeout), button synchroniser with press
// edge detection, and registered LED drive, all slaved to the FSM's estado_* levels.
module temporizador_leds_jogada #(
  parameter int unsigned ON_CYCLES      = 1000,
  parameter int unsigned OFF_CYCLES     = 500,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input logic                         clock,
  input logic                         reset,
  temporizador_leds_jogada_if.slave   bus
);

  localparam int unsigned ON_W  = $clog2(ON_CYCLES);
  localparam int unsigned OFF_W = $clog2(OFF_CYCLES);
  localparam int unsigned T_W   = $clog2(TIMEOUT_CYCLES);

  localparam logic [ON_W-1:0]  ON_LAST  = ON_W'(ON_CYCLES - 1);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(OFF_CYCLES - 1);
  localparam logic [T_W-1:0]   T_LAST   = T_W'(TIMEOUT_CYCLES - 1);

  logic [ON_W-1:0]  cntOn;
  logic [OFF_W-1:0] cntOff;
  logic [T_W-1:0]   cntT;
  logic [3:0]       s1, s2, s3;
  logic [3:0]       ledsQ;
  logic [3:0]       ledsNext;

  // Each phase counter runs only while its estado is high and saturates at its last cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cntOn  <= '0;
      cntOff <= '0;
      cntT   <= '0;
    end else begin
      if (!bus.estado_ledsOn)        cntOn <= '0;
      else if (cntOn != ON_LAST)     cntOn <= cntOn + ON_W'(1);

      if (!bus.estado_ledsOff)       cntOff <= '0;
      else if (cntOff != OFF_LAST)   cntOff <= cntOff + OFF_W'(1);

      if (!bus.estado_espera)        cntT <= '0;
      else if (cntT != T_LAST)       cntT <= cntT + T_W'(1);
    end
  end

  // Two-flop synchroniser plus one history stage for press detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      ledsQ <= '0;
    end else begin
      s1    <= bus.botoes;
      s2    <= s1;
      s3    <= s2;
      ledsQ <= ledsNext;
    end
  end

  always_comb begin
    ledsNext = 4'b0000;
    if (bus.estado_ledsOn)      ledsNext = bus.dado_memoria;
    else if (bus.estado_espera) ledsNext = s2;
  end

  // The counters reset asynchronously, so these terms already read 0 during reset.
  assign bus.fimLedsOn  = bus.estado_ledsOn  & (cntOn  == ON_LAST);
  assign bus.fimLedsOff = bus.estado_ledsOff & (cntOff == OFF_LAST);
  assign bus.timeout    = bus.estado_espera  & (cntT   == T_LAST);
  assign bus.tem_jogada = (|s2) & ~(|s3);
  assign bus.jogada     = s2;
  assign bus.leds       = ledsQ;

endmodule
